led_bank_capture: RTL and testbench

- Receive-side counterpart of the LED bank driver: monitors the shared 9-lane bus (dclk, latch0, latch1, data[8:0]) and rebuilds the 18 frames the driver shifted out.
- Sits on the FPGA fabric as a loopback/readback monitor for self-test and bench checking of the LED path.
- Reports each completed frame set with a one-cycle valid strobe, and flags protocol violations and mid-frame stalls.

---
 rtl/led_bank_capture.sv | 202 ++++++++++++++++++++
 tb/tb_led_bank_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_capture.sv
// ============================================================================
// Module      : led_bank_capture
// Description : Readback monitor for the 9-lane LED bank bus. Rebuilds the
//               18 frames shifted out by the LED bank driver, pulses
//               frame_valid per completed frame set and flags protocol
//               violations and mid-frame stalls.
//               Optional macro LED_CAPTURE_SYNC_EN inserts a 2-flop
//               synchronizer on every bus input (for a foreign clock domain).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_bank_capture #(
  parameter int FRAME_LENGTH = 32,
  parameter int TIMEOUT      = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dclk,
  input  logic                         latch0,
  input  logic                         latch1,
  input  logic [8:0]                   data,
  output logic [18*FRAME_LENGTH-1:0]   frames,
  output logic                         frame_valid,
  output logic                         busy,
  output logic                         proto_err,
  output logic                         err_sticky
);

  localparam int BIT_W  = $clog2(FRAME_LENGTH) + 1;
  localparam int TOUT_W = $clog2(TIMEOUT + 1);
  localparam int ALL_W  = 18 * FRAME_LENGTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT1 = 2'd1,
    S_WAIT0 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bus inputs as seen by the edge detector
  logic       dclk_in;
  logic       latch0_in;
  logic       latch1_in;
  logic [8:0] data_in;

`ifdef LED_CAPTURE_SYNC_EN
  logic [1:0] dclk_sync;
  logic [1:0] latch0_sync;
  logic [1:0] latch1_sync;
  logic [8:0] data_sync1;
  logic [8:0] data_sync2;

  // Two-flop synchronizers; dclk rests high so it resets to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dclk_sync   <= 2'b11;
      latch0_sync <= 2'b00;
      latch1_sync <= 2'b00;
      data_sync1  <= '0;
      data_sync2  <= '0;
    end else begin
      dclk_sync   <= {dclk_sync[0], dclk};
      latch0_sync <= {latch0_sync[0], latch0};
      latch1_sync <= {latch1_sync[0], latch1};
      data_sync1  <= data;
      data_sync2  <= data_sync1;
    end
  end

  assign dclk_in   = dclk_sync[1];
  assign latch0_in = latch0_sync[1];
  assign latch1_in = latch1_sync[1];
  assign data_in   = data_sync2;
`else
  assign dclk_in   = dclk;
  assign latch0_in = latch0;
  assign latch1_in = latch1;
  assign data_in   = data;
`endif

  state_t              state;
  logic                dclk_prev;
  logic [BIT_W-1:0]    bit_cnt;
  logic [TOUT_W-1:0]   quiet_cnt;
  logic [ALL_W-1:0]    shift_all;

  logic                rise;
  logic                grp0;
  logic                grp1;
  logic [BIT_W-1:0]    bit_cnt_next;
  logic                quiet_expire;

  assign rise         = ~dclk_prev & dclk_in;
  assign grp0         = latch0_in & ~latch1_in;
  assign grp1         = latch1_in & ~latch0_in;
  assign bit_cnt_next = bit_cnt + BIT_W'(1);
  // The cycle that would make the quiet count reach TIMEOUT ends the capture
  assign quiet_expire = ~rise && (quiet_cnt == TOUT_W'(TIMEOUT - 1));
  assign busy         = (state == S_WAIT0) || (state == S_WAIT1);

  // Shift one bit into each of the 9 frames of a group; lane 8-i feeds frame i
  function automatic logic [ALL_W-1:0] shift_group(
    input logic [ALL_W-1:0] cur,
    input logic             group,
    input logic [8:0]       lanes
  );
    logic [ALL_W-1:0] res;
    int               base;
    res  = cur;
    base = group ? 9 : 0;
    for (int i = 0; i < 9; i++) begin
      res[(base+i)*FRAME_LENGTH +: FRAME_LENGTH] =
        {cur[(base+i)*FRAME_LENGTH +: FRAME_LENGTH-1], lanes[8-i]};
    end
    return res;
  endfunction

  // Capture FSM, edge detector, bit/quiet counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      dclk_prev   <= 1'b1;
      bit_cnt     <= '0;
      quiet_cnt   <= '0;
      shift_all   <= '0;
      frames      <= '0;
      frame_valid <= 1'b0;
      proto_err   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      proto_err   <= 1'b0;
      dclk_prev   <= dclk_in;

      if (rise) begin
        quiet_cnt <= '0;
      end else if (quiet_cnt != TOUT_W'(TIMEOUT)) begin
        quiet_cnt <= quiet_cnt + TOUT_W'(1);
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) begin
            frames      <= shift_all;
            frame_valid <= 1'b1;
          end
          state <= S_IDLE;
          if (rise && grp0) begin
            shift_all  <= shift_group(shift_all, 1'b0, data_in);
            err_sticky <= 1'b0;
            bit_cnt    <= '0;
            state      <= S_WAIT1;
          end else if (rise && grp1) begin
            proto_err  <= 1'b1;
            err_sticky <= 1'b1;
          end
        end

        S_WAIT1: begin
          if (rise) begin
            if (grp1) begin
              shift_all <= shift_group(shift_all, 1'b1, data_in);
              bit_cnt   <= bit_cnt_next;
              state     <= (bit_cnt_next == BIT_W'(FRAME_LENGTH)) ? S_DONE : S_WAIT0;
            end else begin
              proto_err  <= 1'b1;
              err_sticky <= 1'b1;
              state      <= S_IDLE;
            end
          end else if (quiet_expire) begin
            proto_err  <= 1'b1;
            err_sticky <= 1'b1;
            state      <= S_IDLE;
          end
        end

        S_WAIT0: begin
          if (rise) begin
            if (grp0) begin
              shift_all <= shift_group(shift_all, 1'b0, data_in);
              state     <= S_WAIT1;
            end else begin
              proto_err  <= 1'b1;
              err_sticky <= 1'b1;
              state      <= S_IDLE;
            end
          end else if (quiet_expire) begin
            proto_err  <= 1'b1;
            err_sticky <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_bank_capture.sv
// ============================================================================
// Module      : tb_led_bank_capture
// Description : Self-checking bench for led_bank_capture. Drives driver-like
//               frame sets plus injected faults, and compares every cycle
//               against a frame-set level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_bank_capture;

  localparam int FL = 32;
  localparam int TO = 64;
  localparam int AW = 18 * FL;

  logic          clk = 1'b0;
  logic          rst;
  logic          dclk;
  logic          latch0;
  logic          latch1;
  logic [8:0]    data;
  logic [AW-1:0] frames;
  logic          frame_valid;
  logic          busy;
  logic          proto_err;
  logic          err_sticky;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;

  logic [FL-1:0] cur_set [18];

  led_bank_capture #(.FRAME_LENGTH(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst), .dclk(dclk), .latch0(latch0), .latch1(latch1),
    .data(data), .frames(frames), .frame_valid(frame_valid), .busy(busy),
    .proto_err(proto_err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame-set level) ----------------
  logic          m_prev, m_cap, m_want1, m_done;
  logic          m_valid, m_err, m_sticky;
  int            m_pairs, m_quiet;
  logic [FL-1:0] m_acc [18];
  logic [FL-1:0] m_frames [18];
  logic [1:0]    p_dclk, p_l0, p_l1;
  logic [8:0]    p_d1, p_d2;

  always @(posedge clk or posedge rst) begin
    logic s_dclk, s_l0, s_l1, r, g0, g1;
    logic [8:0] s_d;
    int grp;
    if (rst) begin
      m_prev = 1'b1; m_cap = 1'b0; m_want1 = 1'b0; m_done = 1'b0;
      m_valid = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
      m_pairs = 0; m_quiet = 0;
      for (int k = 0; k < 18; k++) begin m_acc[k] = '0; m_frames[k] = '0; end
      p_dclk = 2'b11; p_l0 = 2'b00; p_l1 = 2'b00; p_d1 = '0; p_d2 = '0;
    end else begin
`ifdef LED_CAPTURE_SYNC_EN
      s_dclk = p_dclk[1]; s_l0 = p_l0[1]; s_l1 = p_l1[1]; s_d = p_d2;
      p_dclk = {p_dclk[0], dclk}; p_l0 = {p_l0[0], latch0};
      p_l1 = {p_l1[0], latch1}; p_d2 = p_d1; p_d1 = data;
`else
      s_dclk = dclk; s_l0 = latch0; s_l1 = latch1; s_d = data;
`endif
      r = !m_prev && s_dclk;
      m_prev = s_dclk;
      g0 = s_l0 && !s_l1;
      g1 = s_l1 && !s_l0;
      m_valid = 1'b0;
      m_err = 1'b0;
      if (m_done) begin
        for (int k = 0; k < 18; k++) m_frames[k] = m_acc[k];
        m_valid = 1'b1;
        m_done = 1'b0;
      end
      grp = -1;
      if (r) begin
        m_quiet = 0;
        if (!m_cap) begin
          if (g0) begin
            grp = 0; m_sticky = 1'b0; m_pairs = 0; m_cap = 1'b1; m_want1 = 1'b1;
          end else if (g1) begin
            m_err = 1'b1; m_sticky = 1'b1;
          end
        end else if (m_want1 && g1) begin
          grp = 1; m_pairs++; m_want1 = 1'b0;
          if (m_pairs == FL) begin m_cap = 1'b0; m_done = 1'b1; end
        end else if (!m_want1 && g0) begin
          grp = 0; m_want1 = 1'b1;
        end else begin
          m_err = 1'b1; m_sticky = 1'b1; m_cap = 1'b0;
        end
      end else begin
        if (m_quiet < TO) m_quiet++;
        if (m_cap && m_quiet == TO) begin
          m_err = 1'b1; m_sticky = 1'b1; m_cap = 1'b0;
        end
      end
      if (grp >= 0)
        for (int i = 0; i < 9; i++)
          m_acc[grp*9+i] = {m_acc[grp*9+i][FL-2:0], s_d[8-i]};
    end
  end

  // ---------------- per-cycle compare + event monitors ----------------
  always @(negedge clk) begin
    logic [AW-1:0] expv;
    for (int k = 0; k < 18; k++) expv[k*FL +: FL] = m_frames[k];
    n_tests++;
    if (frames !== expv || frame_valid !== m_valid || busy !== m_cap ||
        proto_err !== m_err || err_sticky !== m_sticky) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t: got v=%b b=%b e=%b s=%b frames=%h ; expected v=%b b=%b e=%b s=%b frames=%h",
               $time, frame_valid, busy, proto_err, err_sticky, frames,
               m_valid, m_cap, m_err, m_sticky, expv);
    end
    if (frame_valid === 1'b1) n_valid++;
    if (proto_err === 1'b1) n_err++;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] pack_set();
    logic [AW-1:0] v;
    for (int k = 0; k < 18; k++) v[k*FL +: FL] = cur_set[k];
    return v;
  endfunction

  task automatic chk_frames(input string name);
    n_tests++;
    if (frames !== pack_set()) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, frames, pack_set());
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_pulse(input logic l0, input logic l1, input logic [8:0] d);
    latch0 = l0; latch1 = l1; data = d;
    dclk = 1'b0;
    step($urandom_range(1, 3));
    dclk = 1'b1;
    step($urandom_range(1, 3));
  endtask

  task automatic send_bits(input int nbits);
    logic [8:0] d0, d1;
    for (int b = FL - 1; b >= FL - nbits; b--) begin
      for (int i = 0; i < 9; i++) begin
        d0[8-i] = cur_set[i][b];
        d1[8-i] = cur_set[9+i][b];
      end
      send_pulse(1'b1, 1'b0, d0);
      send_pulse(1'b0, 1'b1, d1);
    end
  endtask

  task automatic idle(input int n);
    latch0 = 1'b0; latch1 = 1'b0; dclk = 1'b1;
    step(n);
  endtask

  task automatic rand_set();
    for (int k = 0; k < 18; k++) cur_set[k] = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0, e0;
    logic [AW-1:0] saved;
    rst = 1'b1; dclk = 1'b1; latch0 = 1'b0; latch1 = 1'b0; data = '0;
    step(3);
    chk("reset_frames", 64'(frames == '0), 64'd1);
    chk("reset_valid", 64'(frame_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_sticky", 64'(err_sticky), 64'd0);
    rst = 1'b0;
    idle(2);

    // driver loopback pattern
    for (int k = 0; k < 18; k++) cur_set[k] = 32'h01010101 * k;
    cur_set[0]  = 32'hA5A50001;
    cur_set[17] = 32'h8000000F;
    v0 = n_valid; e0 = n_err;
    send_bits(32); idle(6);
    chk("loop_valid_cnt", 64'(n_valid - v0), 64'd1);
    chk("loop_err_cnt", 64'(n_err - e0), 64'd0);
    chk("loop_frame0", 64'(frames[0 +: 32]), 64'hA5A50001);
    chk("loop_frame5", 64'(frames[5*32 +: 32]), 64'h05050505);
    chk("loop_frame17", 64'(frames[17*32 +: 32]), 64'h8000000F);
    chk_frames("loop_all");

    // back-to-back sets, second is the inverse of the first
    rand_set();
    v0 = n_valid;
    send_bits(32); idle(1);
    for (int k = 0; k < 18; k++) cur_set[k] = ~cur_set[k];
    send_bits(32); idle(6);
    chk("b2b_valid_cnt", 64'(n_valid - v0), 64'd2);
    chk("b2b_sticky", 64'(err_sticky), 64'd0);
    chk_frames("b2b_frames");

    // group-1 rise while waiting for group 0 after 5 bits
    saved = frames;
    rand_set();
    v0 = n_valid; e0 = n_err;
    send_bits(5);
    send_pulse(1'b0, 1'b1, 9'h1FF);
    idle(4);
    chk("inj_err_cnt", 64'(n_err - e0), 64'd1);
    chk("inj_sticky", 64'(err_sticky), 64'd1);
    chk("inj_no_valid", 64'(n_valid - v0), 64'd0);
    chk("inj_frames_kept", 64'(frames == saved), 64'd1);
    rand_set();
    send_bits(32); idle(6);
    chk("recover_sticky", 64'(err_sticky), 64'd0);
    chk_frames("recover_frames");

    // dclk stalls high after bit 10
    rand_set();
    v0 = n_valid; e0 = n_err;
    send_bits(10);
    idle(50);
    chk("stall_busy_early", 64'(busy), 64'd1);
    chk("stall_err_early", 64'(n_err - e0), 64'd0);
    idle(30);
    chk("stall_err_cnt", 64'(n_err - e0), 64'd1);
    chk("stall_busy_late", 64'(busy), 64'd0);
    chk("stall_no_valid", 64'(n_valid - v0), 64'd0);

    // asynchronous reset mid-capture at bit 20
    rand_set();
    send_bits(20);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_frames", 64'(frames == '0), 64'd1);
    chk("arst_sticky", 64'(err_sticky), 64'd0);
    step(2);
    rst = 1'b0;
    idle(3);
    rand_set();
    send_bits(32); idle(6);
    chk_frames("post_reset_frames");

    // both latches in idle: ignored; group 1 alone in idle: error
    e0 = n_err;
    send_pulse(1'b1, 1'b1, 9'h155); idle(3);
    chk("both_idle_err", 64'(n_err - e0), 64'd0);
    chk("both_idle_busy", 64'(busy), 64'd0);
    send_pulse(1'b0, 1'b1, 9'h0AA); idle(3);
    chk("g1_idle_err", 64'(n_err - e0), 64'd1);

    // random sets with occasional faults
    for (int it = 0; it < 8; it++) begin
      rand_set();
      if ($urandom_range(0, 2) == 0) begin
        send_bits($urandom_range(1, 31));
        case ($urandom_range(0, 2))
          0:       send_pulse(1'b0, 1'b1, 9'(($urandom)));
          1:       send_pulse(1'b1, 1'b1, 9'(($urandom)));
          default: send_pulse(1'b0, 1'b0, 9'(($urandom)));
        endcase
        idle(4);
      end else begin
        send_bits(32);
        idle($urandom_range(1, 5));
      end
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
